// File: rtl/fragment_fifo_reader.sv
// Fragment FIFO consumer: pops header + attribute words, reassembles one fragment, presents it downstream.
// Optional screen clipping of out-of-range fragments is enabled by defining FRAG_CLIP_EN.
module fragment_fifo_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [ADDR_WIDTH-1:0] vertexSize,
    output logic                  frag_valid,
    input  logic                  frag_ready,
    output logic [15:0]           frag_x,
    output logic [15:0]           frag_y,
    input  logic [ADDR_WIDTH-1:0] frag_attr_addr,
    output logic [DATA_WIDTH-1:0] frag_attr_data,
    output logic [31:0]           frag_count,
    output logic [15:0]           drop_count,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, READ, PRESENT} state_t;

    // Wide enough to hold N = 2**ADDR_WIDTH + 1 words.
    localparam int CW = ADDR_WIDTH + 2;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] vs_q;
    logic [CW-1:0]         issued, captured, n_words;
    logic                  rd_q, clip_q, hdr_clip, last_cap;
    logic [DATA_WIDTH-1:0] attr_buf [2**ADDR_WIDTH];

    assign n_words  = CW'(vs_q) + CW'(2);
    // rd_q marks that fifo_data carries the word popped last cycle.
    assign last_cap = rd_q && (captured == n_words - CW'(1));

`ifdef FRAG_CLIP_EN
    assign hdr_clip = (32'(fifo_data[31:16]) >= 32'(SCREEN_W)) ||
                      (32'(fifo_data[15:0])  >= 32'(SCREEN_H));
`else
    assign hdr_clip   = 1'b0;
    assign drop_count = 16'd0;
`endif

    always_comb begin
        state_next = state;
        fifo_rd    = 1'b0;
        case (state)
            IDLE: begin
                if (en && !fifo_empty && !reset) begin
                    fifo_rd    = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                fifo_rd = en && !fifo_empty && !reset && (issued < n_words);
                if (last_cap)
                    state_next = clip_q ? IDLE : PRESENT;
            end
            PRESENT: begin
                if (frag_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rd_q       <= 1'b0;
            issued     <= '0;
            captured   <= '0;
            vs_q       <= '0;
            clip_q     <= 1'b0;
            frag_x     <= '0;
            frag_y     <= '0;
            frag_count <= '0;
        end else begin
            state <= state_next;
            rd_q  <= fifo_rd;
            if (state == IDLE && fifo_rd) begin
                vs_q     <= vertexSize;
                issued   <= CW'(1);
                captured <= '0;
                clip_q   <= 1'b0;
            end else if (fifo_rd) begin
                issued <= issued + CW'(1);
            end
            if (rd_q) begin
                if (captured == '0) begin
                    frag_x <= fifo_data[31:16];
                    frag_y <= fifo_data[15:0];
                    clip_q <= hdr_clip;
                end
                captured <= captured + CW'(1);
            end
            if (state == PRESENT && frag_ready)
                frag_count <= frag_count + 32'd1;
        end
    end

`ifdef FRAG_CLIP_EN
    always_ff @(posedge clk) begin
        if (reset)
            drop_count <= '0;
        else if (last_cap && clip_q && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
    end
`endif

    // Attribute store: no reset, contents only meaningful while frag_valid.
    always_ff @(posedge clk) begin
        if (!reset && rd_q && captured != '0)
            attr_buf[ADDR_WIDTH'(captured - CW'(1))] <= fifo_data;
    end

    assign frag_attr_data = attr_buf[frag_attr_addr];
    assign frag_valid     = (state == PRESENT);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_fragment_fifo_reader.sv
// Directed bench for fragment_fifo_reader with a behavioural registered-output FIFO.
module tb_fragment_fifo_reader;
    logic        clk, reset, en, fifo_empty, fifo_rd, frag_valid, frag_ready, busy;
    logic [31:0] fifo_data, frag_attr_data, frag_count;
    logic [3:0]  vertexSize, frag_attr_addr;
    logic [15:0] frag_x, frag_y, drop_count;

    logic [31:0] mem [256];
    logic [7:0]  wr_ptr, rd_ptr;
    logic        hold_empty;
    int          n_checks, n_pass;

    logic [31:0] rdm, vm, la;
    logic [15:0] lx, ly;
    int          herr, viol;

    fragment_fifo_reader dut (
        .clk(clk), .reset(reset), .en(en), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_rd(fifo_rd), .vertexSize(vertexSize), .frag_valid(frag_valid),
        .frag_ready(frag_ready), .frag_x(frag_x), .frag_y(frag_y),
        .frag_attr_addr(frag_attr_addr), .frag_attr_data(frag_attr_data),
        .frag_count(frag_count), .drop_count(drop_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // Runs n cycles from a falling edge, recording per-cycle fifo_rd / frag_valid bit masks,
    // output changes between consecutive valid cycles, and reads that hit empty or valid.
    task automatic run(input int n);
        logic        pv;
        logic [15:0] px, py;
        logic [31:0] pa;
        pv = 1'b0; px = '0; py = '0; pa = '0;
        rdm = '0; vm = '0; herr = 0; viol = 0; lx = '0; ly = '0; la = '0;
        for (int k = 0; k < n; k++) begin
            #1;
            if (fifo_rd) rdm[k] = 1'b1;
            if (fifo_rd && (fifo_empty || frag_valid)) viol++;
            if (frag_valid) begin
                vm[k] = 1'b1;
                if (pv && (frag_x !== px || frag_y !== py || frag_attr_data !== pa)) herr++;
                px = frag_x; py = frag_y; pa = frag_attr_data;
                lx = frag_x; ly = frag_y; la = frag_attr_data;
            end
            pv = frag_valid;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        push(32'h1234_5678);
        en = 1'b1; reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (fifo_rd !== 1'b0) $display("FAIL rst_fifo_rd got %b want 0", fifo_rd); else n_pass++;
        n_checks++; if (frag_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", frag_valid); else n_pass++;
        n_checks++; if ({frag_x, frag_y} !== 32'h0) $display("FAIL rst_xy got %h want 0", {frag_x, frag_y}); else n_pass++;
        n_checks++; if (frag_count !== 32'h0) $display("FAIL rst_count got %0d want 0", frag_count); else n_pass++;
        n_checks++; if (drop_count !== 16'h0) $display("FAIL rst_drop got %0d want 0", drop_count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        en = 1'b0;
        wr_ptr = rd_ptr;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        frag_ready = 1'b1; vertexSize = 4'd3; frag_attr_addr = 4'd2;
        push(32'h0002_0001); push(32'h3f80_0000); push(32'h4000_0000); push(32'h4080_0000); push(32'h0);
        en = 1'b1;
        run(10);
        n_checks++; if (rdm !== 32'h1F) $display("FAIL basic_rd_cycles got %h want 1f", rdm); else n_pass++;
        n_checks++; if (vm !== 32'h40) $display("FAIL basic_valid_cycles got %h want 40", vm); else n_pass++;
        n_checks++; if ({lx, ly} !== 32'h0002_0001) $display("FAIL basic_xy got %h want 00020001", {lx, ly}); else n_pass++;
        n_checks++; if (la !== 32'h4080_0000) $display("FAIL basic_attr2 got %h want 40800000", la); else n_pass++;
        n_checks++; if (frag_count !== 32'd1) $display("FAIL basic_count got %0d want 1", frag_count); else n_pass++;
    endtask

    task automatic test_hold;
        frag_ready = 1'b0; vertexSize = 4'd3; frag_attr_addr = 4'd3;
        push(32'h0002_0001); push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        run(2);
        vertexSize = 4'd0;   // must be ignored mid-fragment
        run(14);
        n_checks++; if (rdm !== 32'h7) $display("FAIL hold_rd_cycles got %h want 7", rdm); else n_pass++;
        n_checks++; if (vm !== 32'h3FF0) $display("FAIL hold_valid_cycles got %h want 3ff0", vm); else n_pass++;
        n_checks++; if (herr !== 0) $display("FAIL hold_stable got %0d changes want 0", herr); else n_pass++;
        n_checks++; if (la !== 32'h44) $display("FAIL hold_attr3 got %h want 44", la); else n_pass++;
        n_checks++; if (frag_count !== 32'd1) $display("FAIL hold_count_wait got %0d want 1", frag_count); else n_pass++;
        frag_ready = 1'b1;
        #1;
        n_checks++; if (frag_valid !== 1'b1) $display("FAIL hold_valid_accept got %b want 1", frag_valid); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (frag_valid !== 1'b0) $display("FAIL hold_valid_after got %b want 0", frag_valid); else n_pass++;
        n_checks++; if (frag_count !== 32'd2) $display("FAIL hold_count_after got %0d want 2", frag_count); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_empty;
        int v;
        vertexSize = 4'd2; frag_attr_addr = 4'd1;
        push(32'h0005_0007); push(32'hAAAA_0000);
        run(7);
        v = viol;
        n_checks++; if (rdm !== 32'h3 || vm !== 32'h0) $display("FAIL empty_first got rd %h vld %h want 3 0", rdm, vm); else n_pass++;
        push(32'hBBBB_0001); push(32'hCCCC_0002);
        run(6);
        v += viol;
        n_checks++; if (rdm !== 32'h3 || vm !== 32'h8) $display("FAIL empty_resume got rd %h vld %h want 3 8", rdm, vm); else n_pass++;
        n_checks++; if (v !== 0) $display("FAIL empty_underflow got %0d want 0", v); else n_pass++;
        n_checks++; if ({lx, ly} !== 32'h0005_0007) $display("FAIL empty_xy got %h want 00050007", {lx, ly}); else n_pass++;
        n_checks++; if (la !== 32'hBBBB_0001) $display("FAIL empty_attr1 got %h want bbbb0001", la); else n_pass++;
        n_checks++; if (frag_count !== 32'd3) $display("FAIL empty_count got %0d want 3", frag_count); else n_pass++;
    endtask

    task automatic test_en_low;
        vertexSize = 4'd1; frag_attr_addr = 4'd1;
        push(32'h0004_0008); push(32'h1111_1111); push(32'h2222_2222);
        run(2);
        en = 1'b0;
        run(4);
        n_checks++; if (rdm !== 32'h0 || vm !== 32'h0) $display("FAIL enlow_idle got rd %h vld %h want 0 0", rdm, vm); else n_pass++;
        en = 1'b1;
        run(4);
        n_checks++; if (rdm !== 32'h1 || vm !== 32'h4) $display("FAIL enlow_resume got rd %h vld %h want 1 4", rdm, vm); else n_pass++;
        n_checks++; if ({lx, ly} !== 32'h0004_0008 || la !== 32'h2222_2222) $display("FAIL enlow_data got %h %h want 00040008 22222222", {lx, ly}, la); else n_pass++;
    endtask

    task automatic test_reset_mid;
        vertexSize = 4'd3;
        push(32'h0009_0003); push(32'h1); push(32'h2); push(32'h3); push(32'h4);
        run(3);
        reset = 1'b1;
        @(negedge clk); #1;
        n_checks++; if ({frag_x, frag_y} !== 32'h0 || busy !== 1'b0 || frag_valid !== 1'b0) $display("FAIL rstmid_state got xy %h busy %b vld %b want 0 0 0", {frag_x, frag_y}, busy, frag_valid); else n_pass++;
        n_checks++; if (frag_count !== 32'h0) $display("FAIL rstmid_count got %0d want 0", frag_count); else n_pass++;
        en = 1'b0;
        wr_ptr = rd_ptr;
        @(negedge clk);
        reset = 1'b0;
        en = 1'b1; vertexSize = 4'd1; frag_attr_addr = 4'd0;
        push(32'h0011_0022); push(32'h5A5A_5A5A); push(32'h6B6B_6B6B);
        run(6);
        n_checks++; if (rdm !== 32'h7 || vm !== 32'h10) $display("FAIL rstmid_next got rd %h vld %h want 7 10", rdm, vm); else n_pass++;
        n_checks++; if ({lx, ly} !== 32'h0011_0022 || la !== 32'h5A5A_5A5A) $display("FAIL rstmid_data got %h %h want 00110022 5a5a5a5a", {lx, ly}, la); else n_pass++;
        n_checks++; if (frag_count !== 32'd1) $display("FAIL rstmid_count_after got %0d want 1", frag_count); else n_pass++;
    endtask

    task automatic test_back_to_back;
        vertexSize = 4'd0; frag_attr_addr = 4'd0;
        push(32'h0001_0001); push(32'hA1); push(32'h0002_0002); push(32'hA2); push(32'h0003_0003); push(32'hA3);
        run(14);
        n_checks++; if (rdm !== 32'h333 || vm !== 32'h888) $display("FAIL b2b_cycles got rd %h vld %h want 333 888", rdm, vm); else n_pass++;
        n_checks++; if (viol !== 0) $display("FAIL b2b_rd_while_valid got %0d want 0", viol); else n_pass++;
        n_checks++; if ({lx, ly} !== 32'h0003_0003 || la !== 32'hA3) $display("FAIL b2b_last got %h %h want 00030003 a3", {lx, ly}, la); else n_pass++;
        n_checks++; if (frag_count !== 32'd4) $display("FAIL b2b_count got %0d want 4", frag_count); else n_pass++;
    endtask

    task automatic test_clip;
        vertexSize = 4'd1; frag_attr_addr = 4'd0;
`ifdef FRAG_CLIP_EN
        push(32'h0280_0000); push(32'hDEAD); push(32'hBEEF);
        push(32'h0001_0001); push(32'h77); push(32'h88);
        run(12);
        n_checks++; if (rdm !== 32'h77 || vm !== 32'h100) $display("FAIL clip_x_cycles got rd %h vld %h want 77 100", rdm, vm); else n_pass++;
        n_checks++; if ({lx, ly} !== 32'h0001_0001 || la !== 32'h77) $display("FAIL clip_x_next got %h %h want 00010001 77", {lx, ly}, la); else n_pass++;
        n_checks++; if (drop_count !== 16'd1) $display("FAIL clip_x_drop got %0d want 1", drop_count); else n_pass++;
        push(32'h0000_01E0); push(32'h1); push(32'h2);
        push(32'h027F_01DF); push(32'h99); push(32'hAA);
        run(12);
        n_checks++; if (rdm !== 32'h77 || vm !== 32'h100) $display("FAIL clip_y_cycles got rd %h vld %h want 77 100", rdm, vm); else n_pass++;
        n_checks++; if ({lx, ly} !== 32'h027F_01DF) $display("FAIL clip_edge_xy got %h want 027f01df", {lx, ly}); else n_pass++;
        n_checks++; if (drop_count !== 16'd2) $display("FAIL clip_y_drop got %0d want 2", drop_count); else n_pass++;
`else
        push(32'h0280_0000); push(32'hDEAD); push(32'hBEEF);
        run(6);
        n_checks++; if (vm !== 32'h10 || {lx, ly} !== 32'h0280_0000) $display("FAIL noclip_present got vld %h xy %h want 10 02800000", vm, {lx, ly}); else n_pass++;
        n_checks++; if (drop_count !== 16'd0) $display("FAIL noclip_drop got %0d want 0", drop_count); else n_pass++;
`endif
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        reset = 1'b1; en = 1'b0; frag_ready = 1'b0; vertexSize = '0; frag_attr_addr = '0;
        wr_ptr = '0; rd_ptr = '0; hold_empty = 1'b0; fifo_data = '0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_hold;
        test_empty;
        test_en_low;
        test_reset_mid;
        test_back_to_back;
        test_clip;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
